lc3b_scoreboard: RTL and testbench
==================================

Name: lc3b_scoreboard

Overview:
- Counter-based register/CC scoreboard. Replaces fixed EX/MEM/WB destination compares with per-register in-flight write counts.
- Sits beside decode. Holds a decoding instruction while any needed source register or needed CC has an outstanding writer.
- Pipeline-depth independent. Width, register count, source count, in-flight depth and WB bypass are parametrised.

Parameters:
- NUM_REGS, 8, architectural registers tracked.
- REG_W, 3, register id width; must equal clog2(NUM_REGS).
- NUM_SRC, 2, source operands checked per instruction.
- CNT_W, 2, per-register/CC counter width; max outstanding writes is 2^CNT_W-1.
- WB_BYPASS, 1, when 1 a retiring write resolves a dependency in the same cycle.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode holds a valid instruction
- dec_src_id  in  NUM_SRC*REG_W  source ids; src k occupies bits [k*REG_W +: REG_W]
- dec_src_needed  in  NUM_SRC  per-source needed flag
- dec_needs_cc  in  1  instruction reads CC (BR)
- dec_ld_reg  in  1  instruction writes a register
- dec_drid  in  REG_W  destination id
- dec_ld_cc  in  1  instruction writes CC
- issue_ready  in  1  downstream accepts an instruction this cycle
- wb_valid  in  1  retire strobe from writeback
- wb_ld_reg  in  1  retiring instruction writes a register
- wb_drid  in  REG_W  retiring destination id
- wb_ld_cc  in  1  retiring instruction writes CC
- flush  in  1  synchronous clear of all pending state
- dep_stall  out  1  decode must hold
- issue  out  1  instruction issues this cycle
- busy  out  1  any counter nonzero
- underflow_err  out  1  sticky retire-at-zero error

Behaviour:
- State: cnt[NUM_REGS] and cc_cnt, each CNT_W bits. Reset (rst_n low, async): all counters 0, underflow_err 0. Outputs reset: dep_stall 0, issue 0, busy 0.
- Hazard on src k: dec_src_needed[k] and cnt[id] != 0. With WB_BYPASS=1 there is no hazard when cnt[id]==1 and wb_valid, wb_ld_reg and wb_drid==id all hold.
- CC hazard: dec_needs_cc and cc_cnt != 0, with the same bypass rule using wb_ld_cc.
- Saturation hazard: dec_ld_reg with cnt[dec_drid] all-ones, or dec_ld_cc with cc_cnt all-ones. No retire credit is taken for saturation.
- dep_stall = dec_valid & (any hazard). It is combinational, with zero-cycle latency from inputs and state. It is 0 whenever dec_valid is 0.
- issue = dec_valid & issue_ready & ~dep_stall.
- WAW is not a hazard: an instruction's own destination never stalls it unless saturated.
- Next state per register r: +1 if issue & dec_ld_reg & dec_drid==r; -1 if wb_valid & wb_ld_reg & wb_drid==r & cnt[r]!=0. Both in the same cycle give net 0. CC uses the same rule.
- Retire with wb_ld_reg set and cnt[wb_drid]==0 (or CC at 0): counter holds 0 and underflow_err sets. It clears only on reset.
- flush: next state of every counter is 0, overriding issue and retire in that cycle. Issue is still reported combinationally. Caller guarantees no surviving older writer is in flight when flush is asserted.
- busy = OR of all counter != 0 (registered state, not next state).

Decomposition:
- Add to lc3b_types: lc3b_reg (existing), and typedef lc3b_sb_cnt as logic [CNT_W-1:0] at default width.
- Sub-module sb_counter holds one up/down saturating counter with inc, dec, clr, zero, full and underflow outputs. It is instantiated NUM_REGS+1 times (registers plus CC) in a generate loop.

Test Plan:
- Reset, then issue ADD R1 (ld_reg, drid=1) with issue_ready=1. Next decode reads src R1 -> dep_stall=1, issue=0, busy=1.
- From cnt[1]=1, assert wb_valid, wb_ld_reg, wb_drid=1 in the same cycle as decode needs R1. WB_BYPASS=1 -> dep_stall=0, issue=1. WB_BYPASS=0 -> dep_stall=1 that cycle, 0 the next.
- Issue three writes to R2 with no retire (CNT_W=2, cnt=3). A fourth instruction writing R2 -> dep_stall=1. Retire one R2 -> the fourth issues next cycle with cnt remaining 3.
- Issue a CC writer, then decode BR (dec_needs_cc=1, no sources) -> stall until the CC writer retires; cc_cnt returns to 0 and busy=0.
- Simultaneous issue writing R3 and retire of R3 with cnt[3]=1 -> cnt[3] stays 1. Retire R4 at cnt[4]=0 -> underflow_err=1 and cnt[4]=0.
- With counters nonzero, assert flush with a concurrent issue -> all counters 0 next cycle, busy=0. Drop rst_n mid-sequence -> counters and underflow_err clear immediately, asynchronously.

Source files
------------

// File: rtl/lc3b_scoreboard_pkg.sv
// Shared types and default sizes for the LC-3b decode scoreboard.
//   lc3b_reg    : architectural register id
//   lc3b_sb_cnt : per-register / CC in-flight write counter at default width
package lc3b_scoreboard_pkg;

  localparam int unsigned LC3B_NUM_REGS = 8;
  localparam int unsigned LC3B_REG_W    = 3;
  localparam int unsigned LC3B_NUM_SRC  = 2;
  localparam int unsigned LC3B_SB_CNT_W = 2;

  typedef logic [LC3B_REG_W-1:0]    lc3b_reg;
  typedef logic [LC3B_SB_CNT_W-1:0] lc3b_sb_cnt;

endpackage

// File: rtl/lc3b_scoreboard_if.sv
// Decode/writeback bundle between the pipeline and the scoreboard.
//   master : decode + writeback side (drives dec_*, wb_*, issue_ready, flush)
//   slave  : scoreboard (drives dep_stall, issue, busy, underflow_err)
interface lc3b_scoreboard_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_W   = 3
);

  logic                     dec_valid;
  logic [NUM_SRC*REG_W-1:0] dec_src_id;
  logic [NUM_SRC-1:0]       dec_src_needed;
  logic                     dec_needs_cc;
  logic                     dec_ld_reg;
  logic [REG_W-1:0]         dec_drid;
  logic                     dec_ld_cc;
  logic                     issue_ready;
  logic                     wb_valid;
  logic                     wb_ld_reg;
  logic [REG_W-1:0]         wb_drid;
  logic                     wb_ld_cc;
  logic                     flush;
  logic                     dep_stall;
  logic                     issue;
  logic                     busy;
  logic                     underflow_err;

  modport master (
    output dec_valid, dec_src_id, dec_src_needed, dec_needs_cc, dec_ld_reg,
           dec_drid, dec_ld_cc, issue_ready, wb_valid, wb_ld_reg, wb_drid,
           wb_ld_cc, flush,
    input  dep_stall, issue, busy, underflow_err
  );

  modport slave (
    input  dec_valid, dec_src_id, dec_src_needed, dec_needs_cc, dec_ld_reg,
           dec_drid, dec_ld_cc, issue_ready, wb_valid, wb_ld_reg, wb_drid,
           wb_ld_cc, flush,
    output dep_stall, issue, busy, underflow_err
  );

endinterface

// File: rtl/lc3b_scoreboard_sb_counter.sv
// One in-flight write counter (register or CC).
//   inc       : an issuing instruction writes this resource
//   dec       : a retiring instruction writes this resource
//   clr       : synchronous clear, overrides inc/dec
//   cnt       : registered count
//   zero/full : count is 0 / all-ones
//   underflow : retire seen while the count is 0 (count holds at 0)
module sb_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         full,
  output logic         underflow
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         inc_ok;
  logic         dec_ok;

  assign zero      = (cnt_q == '0);
  assign full      = (cnt_q == '1);
  assign underflow = dec & zero;
  assign inc_ok    = inc & ~full;
  assign dec_ok    = dec & ~zero;
  assign cnt       = cnt_q;

  // Simultaneous accepted inc and dec cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc_ok && !dec_ok) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lc3b_scoreboard.sv
// Counter-based register/CC scoreboard beside decode.
//   clk, rst_n : clock, async active-low reset
//   sb (slave) : decode request, writeback retire, flush in;
//                dep_stall/issue (combinational), busy, sticky underflow_err out
// Counter index NUM_REGS is the condition-code counter.
module lc3b_scoreboard
  import lc3b_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS  = LC3B_NUM_REGS,
  parameter int unsigned REG_W     = LC3B_REG_W,
  parameter int unsigned NUM_SRC   = LC3B_NUM_SRC,
  parameter int unsigned CNT_W     = LC3B_SB_CNT_W,
  parameter int unsigned WB_BYPASS = 1
) (
  input logic              clk,
  input logic              rst_n,
  lc3b_scoreboard_if.slave sb
);

  localparam int unsigned NUM_CTR = NUM_REGS + 1;
  localparam int unsigned CC_IDX  = NUM_REGS;
  localparam bit          BYP     = (WB_BYPASS != 0);

  logic [NUM_CTR-1:0]  ctr_inc;
  logic [NUM_CTR-1:0]  ctr_dec;
  logic [NUM_CTR-1:0]  ctr_zero;
  logic [NUM_CTR-1:0]  ctr_full;
  logic [NUM_CTR-1:0]  ctr_one;
  logic [NUM_CTR-1:0]  ctr_uf;
  logic [CNT_W-1:0]    ctr_cnt [NUM_CTR];

  logic [NUM_REGS-1:0] reg_zero;
  logic [NUM_REGS-1:0] reg_full;
  logic [NUM_REGS-1:0] reg_one;

  logic                wb_reg;
  logic                wb_cc;
  logic                hazard;
  logic [REG_W-1:0]    src;
  logic                dep_stall_c;
  logic                issue_c;
  logic                underflow_q;

  for (genvar g = 0; g < NUM_CTR; g++) begin : g_ctr
    sb_counter #(.W(CNT_W)) u_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (ctr_inc[g]),
      .dec       (ctr_dec[g]),
      .clr       (sb.flush),
      .cnt       (ctr_cnt[g]),
      .zero      (ctr_zero[g]),
      .full      (ctr_full[g]),
      .underflow (ctr_uf[g])
    );
    assign ctr_one[g] = (ctr_cnt[g] == CNT_W'(1));
  end

  assign reg_zero = ctr_zero[NUM_REGS-1:0];
  assign reg_full = ctr_full[NUM_REGS-1:0];
  assign reg_one  = ctr_one[NUM_REGS-1:0];
  assign wb_reg   = sb.wb_valid & sb.wb_ld_reg;
  assign wb_cc    = sb.wb_valid & sb.wb_ld_cc;

  // RAW on sources/CC (a last-writer retiring now resolves it when bypassing),
  // plus saturation of the destination counters.
  always_comb begin
    hazard = 1'b0;
    src    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src = sb.dec_src_id[k*REG_W +: REG_W];
      if (sb.dec_src_needed[k] && !reg_zero[src] &&
          !(BYP && reg_one[src] && wb_reg && (sb.wb_drid == src))) begin
        hazard = 1'b1;
      end
    end
    if (sb.dec_needs_cc && !ctr_zero[CC_IDX] &&
        !(BYP && ctr_one[CC_IDX] && wb_cc)) begin
      hazard = 1'b1;
    end
    if (sb.dec_ld_reg && reg_full[sb.dec_drid]) begin
      hazard = 1'b1;
    end
    if (sb.dec_ld_cc && ctr_full[CC_IDX]) begin
      hazard = 1'b1;
    end
  end

  assign dep_stall_c = sb.dec_valid & hazard;
  assign issue_c     = sb.dec_valid & sb.issue_ready & ~dep_stall_c;

  // Counter strobes from the issuing and retiring instructions.
  always_comb begin
    ctr_inc = '0;
    ctr_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      ctr_inc[r] = issue_c & sb.dec_ld_reg & (sb.dec_drid == REG_W'(r));
      ctr_dec[r] = wb_reg & (sb.wb_drid == REG_W'(r));
    end
    ctr_inc[CC_IDX] = issue_c & sb.dec_ld_cc;
    ctr_dec[CC_IDX] = wb_cc;
  end

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else if (|ctr_uf) begin
      underflow_q <= 1'b1;
    end
  end

  assign sb.dep_stall     = dep_stall_c;
  assign sb.issue         = issue_c;
  assign sb.busy          = ~(&ctr_zero);
  assign sb.underflow_err = underflow_q;

endmodule

// File: tb/tb_lc3b_scoreboard.sv
// Self-checking bench: a bypassing and a non-bypassing scoreboard driven
// with the same stimulus, each compared against its own count-array model.
module tb_lc3b_scoreboard;
  import lc3b_scoreboard_pkg::*;

  localparam int NR   = 8;
  localparam int NC   = NR + 1;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       dec_valid, needs_cc, ld_reg, ld_cc, issue_ready;
  logic       wb_valid, wb_ld_reg, wb_ld_cc, flush;
  logic [1:0] src_needed;
  lc3b_reg    src0, src1, drid, wb_drid;

  logic [1:0] obs_stall, obs_issue, obs_busy, obs_uf;

  lc3b_scoreboard_if #(.NUM_SRC(2), .REG_W(3)) sbif_byp ();
  lc3b_scoreboard_if #(.NUM_SRC(2), .REG_W(3)) sbif_nob ();

  assign sbif_byp.dec_valid      = dec_valid;
  assign sbif_byp.dec_src_id     = {src1, src0};
  assign sbif_byp.dec_src_needed = src_needed;
  assign sbif_byp.dec_needs_cc   = needs_cc;
  assign sbif_byp.dec_ld_reg     = ld_reg;
  assign sbif_byp.dec_drid       = drid;
  assign sbif_byp.dec_ld_cc      = ld_cc;
  assign sbif_byp.issue_ready    = issue_ready;
  assign sbif_byp.wb_valid       = wb_valid;
  assign sbif_byp.wb_ld_reg      = wb_ld_reg;
  assign sbif_byp.wb_drid        = wb_drid;
  assign sbif_byp.wb_ld_cc       = wb_ld_cc;
  assign sbif_byp.flush          = flush;

  assign sbif_nob.dec_valid      = dec_valid;
  assign sbif_nob.dec_src_id     = {src1, src0};
  assign sbif_nob.dec_src_needed = src_needed;
  assign sbif_nob.dec_needs_cc   = needs_cc;
  assign sbif_nob.dec_ld_reg     = ld_reg;
  assign sbif_nob.dec_drid       = drid;
  assign sbif_nob.dec_ld_cc      = ld_cc;
  assign sbif_nob.issue_ready    = issue_ready;
  assign sbif_nob.wb_valid       = wb_valid;
  assign sbif_nob.wb_ld_reg      = wb_ld_reg;
  assign sbif_nob.wb_drid        = wb_drid;
  assign sbif_nob.wb_ld_cc       = wb_ld_cc;
  assign sbif_nob.flush          = flush;

  assign obs_stall = {sbif_nob.dep_stall, sbif_byp.dep_stall};
  assign obs_issue = {sbif_nob.issue, sbif_byp.issue};
  assign obs_busy  = {sbif_nob.busy, sbif_byp.busy};
  assign obs_uf    = {sbif_nob.underflow_err, sbif_byp.underflow_err};

  lc3b_scoreboard #(.WB_BYPASS(1)) dut_byp (
    .clk (clk), .rst_n (rst_n), .sb (sbif_byp)
  );

  lc3b_scoreboard #(.WB_BYPASS(0)) dut_nob (
    .clk (clk), .rst_n (rst_n), .sb (sbif_nob)
  );

  // Reference: outstanding write count per register (index NR = CC).
  int mcnt [2][NC];
  bit muf  [2];
  bit m_issue [2];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NC; r++) mcnt[d][r] = 0;
      muf[d] = 1'b0;
    end
  endtask

  function automatic bit model_busy(int d);
    for (int r = 0; r < NC; r++) if (mcnt[d][r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // d == 0 is the bypassing instance.
  function automatic bit model_stall(int d);
    int ids [2];
    bit h;
    ids[0] = int'(src0);
    ids[1] = int'(src1);
    h = 1'b0;
    if (dec_valid !== 1'b1) return 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (src_needed[k] && mcnt[d][ids[k]] != 0 &&
          !(d == 0 && mcnt[d][ids[k]] == 1 && wb_valid && wb_ld_reg &&
            int'(wb_drid) == ids[k]))
        h = 1'b1;
    end
    if (needs_cc && mcnt[d][NR] != 0 &&
        !(d == 0 && mcnt[d][NR] == 1 && wb_valid && wb_ld_cc))
      h = 1'b1;
    if (ld_reg && mcnt[d][int'(drid)] == CMAX) h = 1'b1;
    if (ld_cc && mcnt[d][NR] == CMAX) h = 1'b1;
    return h;
  endfunction

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NC; r++) begin
        automatic int  old = mcnt[d][r];
        automatic bit  wr  = (r < NR) ? (ld_reg && int'(drid) == r) : ld_cc;
        automatic bit  rt  = wb_valid && ((r < NR) ? (wb_ld_reg && int'(wb_drid) == r) : wb_ld_cc);
        if (m_issue[d] && wr) mcnt[d][r] = mcnt[d][r] + 1;
        if (rt) begin
          if (old != 0) mcnt[d][r] = mcnt[d][r] - 1;
          else muf[d] = 1'b1;
        end
        if (flush) mcnt[d][r] = 0;
      end
    end
  endtask

  // Entered at a falling edge with inputs set; checks, then advances one cycle.
  task automatic step(input string tag);
    bit st;
    #1;
    for (int d = 0; d < 2; d++) begin
      st = model_stall(d);
      m_issue[d] = dec_valid && issue_ready && !st;
      check($sformatf("%s.stall%0d", tag, d), 32'(obs_stall[d]), 32'(st));
      check($sformatf("%s.issue%0d", tag, d), 32'(obs_issue[d]), 32'(m_issue[d]));
      check($sformatf("%s.busy%0d", tag, d), 32'(obs_busy[d]), 32'(model_busy(d)));
      check($sformatf("%s.uf%0d", tag, d), 32'(obs_uf[d]), 32'(muf[d]));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic dec_set(input bit v, input bit n0, input int s0, input bit n1,
                         input int s1, input bit ncc, input bit lr, input int d,
                         input bit lc);
    dec_valid  = v;
    src_needed = {n1, n0};
    src0       = lc3b_reg'(s0);
    src1       = lc3b_reg'(s1);
    needs_cc   = ncc;
    ld_reg     = lr;
    drid       = lc3b_reg'(d);
    ld_cc      = lc;
  endtask

  task automatic wb_set(input bit v, input bit lr, input int d, input bit lc);
    wb_valid  = v;
    wb_ld_reg = lr;
    wb_drid   = lc3b_reg'(d);
    wb_ld_cc  = lc;
  endtask

  initial begin
    rst_n       = 1'b0;
    issue_ready = 1'b1;
    flush       = 1'b0;
    dec_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_set(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst.busy", 32'(obs_busy), 32'd0);
    check("rst.uf", 32'(obs_uf), 32'd0);
    check("rst.stall", 32'(obs_stall), 32'd0);
    check("rst.issue", 32'(obs_issue), 32'd0);
    rst_n = 1'b1;
    step("idle");

    // ADD R1, then a reader of R1
    dec_set(1, 0, 0, 0, 0, 0, 1, 1, 0);
    step("add_r1");
    dec_set(1, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    check("raw.stall", 32'(obs_stall[0]), 32'd1);
    check("raw.issue", 32'(obs_issue[0]), 32'd0);
    check("raw.busy", 32'(obs_busy[0]), 32'd1);
    step("raw");
    wb_set(1, 1, 1, 0);
    #1;
    check("byp.stall", 32'(obs_stall[0]), 32'd0);
    check("byp.issue", 32'(obs_issue[0]), 32'd1);
    check("nobyp.stall", 32'(obs_stall[1]), 32'd1);
    step("byp");
    wb_set(0, 0, 0, 0);
    #1;
    check("nobyp.next", 32'(obs_stall[1]), 32'd0);
    step("byp_next");

    // Saturate R2
    dec_set(1, 0, 0, 0, 0, 0, 1, 2, 0);
    repeat (3) step("r2_w");
    #1;
    check("sat.stall", 32'(obs_stall[0]), 32'd1);
    step("sat");
    wb_set(1, 1, 2, 0);
    #1;
    check("sat.nocredit", 32'(obs_stall[0]), 32'd1);
    step("sat_wb");
    wb_set(0, 0, 0, 0);
    #1;
    check("sat.go", 32'(obs_issue[0]), 32'd1);
    step("sat_go");
    #1;
    check("sat.still3", 32'(obs_stall[0]), 32'd1);
    step("sat_still");
    dec_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_set(1, 1, 2, 0);
    repeat (3) step("r2_rt");
    wb_set(0, 0, 0, 0);

    // CC writer then BR
    dec_set(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("cc_w");
    dec_set(1, 0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    check("cc.stall", 32'(obs_stall[0]), 32'd1);
    repeat (2) step("br_hold");
    wb_set(1, 0, 0, 1);
    step("cc_wb");
    wb_set(0, 0, 0, 0);
    step("cc_after");
    dec_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("cc.busy", 32'(obs_busy), 32'd0);
    step("cc_idle");

    // Concurrent issue/retire on R3, underflow on R4
    dec_set(1, 0, 0, 0, 0, 0, 1, 3, 0);
    step("r3_w");
    wb_set(1, 1, 3, 0);
    step("r3_both");
    wb_set(0, 0, 0, 0);
    dec_set(1, 1, 3, 0, 0, 0, 0, 0, 0);
    #1;
    check("r3.kept", 32'(obs_stall[0]), 32'd1);
    step("r3_read");
    dec_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_set(1, 1, 3, 0);
    step("r3_rt");
    wb_set(1, 1, 4, 0);
    step("r4_uf");
    wb_set(0, 0, 0, 0);
    #1;
    check("uf.set", 32'(obs_uf), 32'd3);
    check("uf.busy", 32'(obs_busy), 32'd0);
    step("uf_after");

    // Flush with a concurrent issue
    dec_set(1, 0, 0, 0, 0, 0, 1, 5, 0);
    step("r5_w");
    dec_set(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("cc_w2");
    dec_set(1, 0, 0, 0, 0, 0, 1, 7, 0);
    flush = 1'b1;
    #1;
    check("flush.issue", 32'(obs_issue[0]), 32'd1);
    step("flush");
    flush = 1'b0;
    dec_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("flush.busy", 32'(obs_busy), 32'd0);
    step("flush_after");

    // Async reset mid-cycle
    dec_set(1, 0, 0, 0, 0, 0, 1, 6, 0);
    repeat (2) step("r6_w");
    dec_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("arst.pre_busy", 32'(obs_busy), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("arst.busy", 32'(obs_busy), 32'd0);
    check("arst.uf", 32'(obs_uf), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("arst_after");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      dec_set(1'($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 3)),
              1'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
              1'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
      wb_set(1'($urandom), 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) == 0));
      issue_ready = 1'($urandom_range(0, 3) != 0);
      flush       = 1'($urandom_range(0, 31) == 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
